// File: rtl/pla_eval_pkg.sv
// Shared constants and helpers for the PLA evaluation engine.
package pla_eval_pkg;

  localparam int DEF_N_IN   = 4;
  localparam int DEF_N_OUT  = 7;
  localparam int DEF_N_TERM = 16;
  localparam int CNT_W      = 32;
  localparam int PIPE_LAT   = 2;

  // Number of set bits in a 32-bit word, used to score output toggles.
  function automatic logic [CNT_W-1:0] popcount32(input logic [31:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) n = n + CNT_W'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/pla_term_array.sv
// Product-term table: per-slot enable, care mask, required values and
// OR-plane mask, plus the combinational match vector for one lookup.
module pla_term_array
  import pla_eval_pkg::*;
#(
  parameter int N_IN   = DEF_N_IN,
  parameter int N_OUT  = DEF_N_OUT,
  parameter int N_TERM = DEF_N_TERM,
  localparam int TW    = $clog2(N_TERM)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [TW-1:0]     wr_idx,
  input  logic              wr_term_en,
  input  logic [N_IN-1:0]   wr_care,
  input  logic [N_IN-1:0]   wr_val,
  input  logic [N_OUT-1:0]  wr_out,
  input  logic [N_IN-1:0]   lookup,
  output logic [N_TERM-1:0] match,
  output logic [N_OUT-1:0]  term_out [N_TERM]
);

  logic [N_TERM-1:0] en_q, en_d;
  logic [N_IN-1:0]   care_q [N_TERM];
  logic [N_IN-1:0]   care_d [N_TERM];
  logic [N_IN-1:0]   val_q  [N_TERM];
  logic [N_IN-1:0]   val_d  [N_TERM];
  logic [N_OUT-1:0]  out_q  [N_TERM];
  logic [N_OUT-1:0]  out_d  [N_TERM];

  // Slot write: indices with no matching slot fall through untouched.
  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    en_d   = en_q;
    care_d = care_q;
    val_d  = val_q;
    out_d  = out_q;
    for (int t = 0; t < N_TERM; t++) begin
      if (wr_en && (wr_idx == TW'(t))) begin
        en_d[t]   = wr_term_en;
        care_d[t] = wr_care;
        val_d[t]  = wr_val;
        out_d[t]  = wr_out;
      end
    end
  end

  // Enables are the only reset state of the table.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment to avoid update races.
    if (rst) en_q <= '0;
    else     en_q <= en_d;
  end

  // Term contents.
  always_ff @(posedge clk) begin
    // NOTE: the table payload is deliberately unreset; a cleared enable hides it.
    care_q <= care_d;
    val_q  <= val_d;
    out_q  <= out_d;
  end

  // A term matches when enabled and every cared-for bit equals its value.
  always_comb begin
    match = '0;
    for (int t = 0; t < N_TERM; t++)
      match[t] = en_q[t] && (((lookup ^ val_q[t]) & care_q[t]) == '0);
  end

  assign term_out = out_q;

endmodule

// File: rtl/pla_eval_engine.sv
// PLA evaluation engine: term-write port, two-stage evaluation pipeline
// (S1 = match vector, S2 = OR result) with valid/ready handshakes.
// Optional output toggle counter enabled by PLA_TOGGLE_CNT_EN.
module pla_eval_engine
  import pla_eval_pkg::*;
#(
  parameter int N_IN   = DEF_N_IN,
  parameter int N_OUT  = DEF_N_OUT,
  parameter int N_TERM = DEF_N_TERM,
  localparam int TW    = $clog2(N_TERM)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [TW-1:0]    cfg_idx,
  input  logic             cfg_en,
  input  logic [N_IN-1:0]  cfg_care,
  input  logic [N_IN-1:0]  cfg_val,
  input  logic [N_OUT-1:0] cfg_out,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_IN-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef PLA_TOGGLE_CNT_EN
  input  logic             toggle_clr,
  output logic [CNT_W-1:0] toggle_cnt,
`endif
  output logic [N_OUT-1:0] out_data
);

  logic              s1_valid_q, s1_valid_d;
  logic [N_TERM-1:0] s1_match_q, s1_match_d;
  logic              s2_valid_q, s2_valid_d;
  logic [N_OUT-1:0]  s2_data_q, s2_data_d;
  logic [N_TERM-1:0] term_match;
  logic [N_OUT-1:0]  term_out [N_TERM];
  logic [N_OUT-1:0]  or_result;
  logic              s2_free;
  logic              cfg_fire;

  pla_term_array #(
    .N_IN  (N_IN),
    .N_OUT (N_OUT),
    .N_TERM(N_TERM)
  ) u_terms (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (cfg_fire),
    .wr_idx    (cfg_idx),
    .wr_term_en(cfg_en),
    .wr_care   (cfg_care),
    .wr_val    (cfg_val),
    .wr_out    (cfg_out),
    .lookup    (in_data),
    .match     (term_match),
    .term_out  (term_out)
  );

  // Handshakes; term writes only when nothing is in flight or arriving.
  always_comb begin
    s2_free   = !s2_valid_q || out_ready;
    in_ready  = !rst && (!s1_valid_q || s2_free);
    cfg_ready = !rst && !s1_valid_q && !s2_valid_q && !in_valid;
    cfg_fire  = cfg_valid && cfg_ready;
    out_valid = !rst && s2_valid_q;
    out_data  = rst ? '0 : s2_data_q;
  end

  // OR plane over the registered match vector.
  always_comb begin
    or_result = '0;
    for (int t = 0; t < N_TERM; t++)
      if (s1_match_q[t]) or_result = or_result | term_out[t];
  end

  // Pipeline advance: S2 holds its result while stalled or empty.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_match_d = s1_match_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) s1_match_d = term_match;
    end
    if (s2_free) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) s2_data_d = or_result;
    end
  end

  // Pipeline registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_match_q <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_match_q <= s1_match_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
    end
  end

`ifdef PLA_TOGGLE_CNT_EN
  logic [CNT_W-1:0] toggle_cnt_q, toggle_cnt_d;
  logic [N_OUT-1:0] prev_out_q, prev_out_d;
  logic [CNT_W:0]   toggle_sum;

  // Saturating toggle accumulation per out handshake; clear wins.
  always_comb begin
    toggle_sum   = {1'b0, toggle_cnt_q}
                 + {1'b0, popcount32(32'(s2_data_q ^ prev_out_q))};
    toggle_cnt_d = toggle_cnt_q;
    prev_out_d   = prev_out_q;
    if (out_valid && out_ready) begin
      prev_out_d   = s2_data_q;
      toggle_cnt_d = toggle_sum[CNT_W] ? '1 : toggle_sum[CNT_W-1:0];
    end
    if (toggle_clr) toggle_cnt_d = '0;
  end

  // Toggle counter and previous-output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      toggle_cnt_q <= '0;
      prev_out_q   <= '0;
    end else begin
      toggle_cnt_q <= toggle_cnt_d;
      prev_out_q   <= prev_out_d;
    end
  end

  assign toggle_cnt = rst ? '0 : toggle_cnt_q;
`endif

endmodule

// File: tb/tb_pla_eval_engine.sv
// Self-checking bench for pla_eval_engine with a scoreboard queue.
module tb_pla_eval_engine;
  import pla_eval_pkg::*;

  localparam int N_IN   = 4;
  localparam int N_OUT  = 7;
  localparam int N_TERM = 16;
  localparam int TW     = 4;

  logic             clk;
  logic             rst;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [TW-1:0]    cfg_idx;
  logic             cfg_en;
  logic [N_IN-1:0]  cfg_care;
  logic [N_IN-1:0]  cfg_val;
  logic [N_OUT-1:0] cfg_out;
  logic             in_valid;
  logic             in_ready;
  logic [N_IN-1:0]  in_data;
  logic             out_valid;
  logic             out_ready;
  logic [N_OUT-1:0] out_data;
`ifdef PLA_TOGGLE_CNT_EN
  logic             toggle_clr;
  logic [31:0]      toggle_cnt;
`endif

  pla_eval_engine #(.N_IN(N_IN), .N_OUT(N_OUT), .N_TERM(N_TERM)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_idx   (cfg_idx),
    .cfg_en    (cfg_en),
    .cfg_care  (cfg_care),
    .cfg_val   (cfg_val),
    .cfg_out   (cfg_out),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef PLA_TOGGLE_CNT_EN
    .toggle_clr(toggle_clr),
    .toggle_cnt(toggle_cnt),
`endif
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference table and scoreboard.
  logic             m_en   [N_TERM];
  logic [N_IN-1:0]  m_care [N_TERM];
  logic [N_IN-1:0]  m_val  [N_TERM];
  logic [N_OUT-1:0] m_out  [N_TERM];
  logic [N_OUT-1:0] exp_q [$];
  logic [31:0]      exp_tog;
  logic [N_OUT-1:0] m_prev;
  int               n_out = 0;
  bit               saw_stall = 0;

  function automatic logic [N_OUT-1:0] model_eval(input logic [N_IN-1:0] d);
    logic [N_OUT-1:0] r;
    r = '0;
    for (int t = 0; t < N_TERM; t++)
      if (m_en[t] && (((d ^ m_val[t]) & m_care[t]) == '0)) r = r | m_out[t];
    return r;
  endfunction

  // Monitor: sample mid-cycle, ahead of the edge where handshakes occur.
  always @(negedge clk) begin
    logic [N_OUT-1:0] e;
    logic [32:0]      s;
    if (rst) begin
      for (int t = 0; t < N_TERM; t++) m_en[t] = 1'b0;
      exp_q.delete();
      exp_tog = '0;
      m_prev  = '0;
    end else begin
`ifdef PLA_TOGGLE_CNT_EN
      check("toggle_cnt", toggle_cnt, exp_tog);
`endif
      if (!in_ready) saw_stall = 1;
      if (cfg_valid && cfg_ready) begin
        m_en[cfg_idx]   = cfg_en;
        m_care[cfg_idx] = cfg_care;
        m_val[cfg_idx]  = cfg_val;
        m_out[cfg_idx]  = cfg_out;
      end
      if (in_valid && in_ready) exp_q.push_back(model_eval(in_data));
      if (out_valid && out_ready) begin
        check("out_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("out_data", 32'(out_data), 32'(e));
          n_out++;
          s = {1'b0, exp_tog} + 33'($countones(e ^ m_prev));
          exp_tog = s[32] ? 32'hFFFF_FFFF : s[31:0];
          m_prev  = e;
        end
      end
`ifdef PLA_TOGGLE_CNT_EN
      if (toggle_clr) exp_tog = '0;
`endif
    end
  end

  // Drivers start just after a rising edge and leave just after the handshake edge.
  task automatic send(input logic [N_IN-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (!in_ready) check("in_hs_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic cfg_write(input logic [TW-1:0] idx, input logic en,
                           input logic [N_IN-1:0] care, input logic [N_IN-1:0] val,
                           input logic [N_OUT-1:0] o);
    cfg_valid = 1'b1;
    cfg_idx   = idx;
    cfg_en    = en;
    cfg_care  = care;
    cfg_val   = val;
    cfg_out   = o;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cfg_ready) break;
    end
    if (!cfg_ready) check("cfg_hs_timeout", 32'(cfg_ready), 32'd1);
    @(posedge clk);
    #1 cfg_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int n0;
    rst = 1'b1; cfg_valid = 1'b0; cfg_idx = '0; cfg_en = 1'b0;
    cfg_care = '0; cfg_val = '0; cfg_out = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
`ifdef PLA_TOGGLE_CNT_EN
    toggle_clr = 1'b0;
`endif
    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_cfg_ready", 32'(cfg_ready), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd0);
`ifdef PLA_TOGGLE_CNT_EN
    check("rst_toggle", toggle_cnt, 32'd0);
`endif
    @(posedge clk);
    #1 rst = 1'b0;
    #1 check("in_ready_after_rst", 32'(in_ready), 32'd1);

    // Empty table, two-cycle latency.
    send(4'hA);
    check("lat_cycle1", 32'(out_valid), 32'd0);
    idle(1);
    check("lat_cycle2", 32'(out_valid), 32'd1);
    check("lat_data",   32'(out_data),  32'd0);
    idle(2);

    // Two terms, three vectors.
    cfg_write(4'd0, 1'b1, 4'hF, 4'h0, 7'h7F);
    cfg_write(4'd1, 1'b1, 4'h8, 4'h8, 7'h01);
    send(4'h0); send(4'h8); send(4'h3);
    idle(4);

    // Backpressure during a 10-vector stream.
    saw_stall = 0;
    n0 = n_out;
    fork
      for (int i = 0; i < 10; i++) send(4'($urandom_range(0, 15)));
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    idle(6);
    check("stall_in_ready_fell", 32'(saw_stall), 32'd1);
    check("stream_count", 32'(n_out - n0), 32'd10);

    // Term write requested with two vectors in flight.
    send(4'h8); send(4'h0);
    fork
      cfg_write(4'd1, 1'b1, 4'h8, 4'h8, 7'h55);
      begin
        @(negedge clk);
        check("cfg_ready_busy", 32'(cfg_ready), 32'd0);
      end
    join
    send(4'hC);
    idle(4);

    // Reset with both stages full.
    out_ready = 1'b0;
    send(4'h0); send(4'h8);
    check("full_before_rst", 32'(out_valid), 32'd1);
    rst = 1'b1;
    idle(1);
    check("rst_mid_out_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    n0 = n_out;
    idle(4);
    check("no_stale_out", 32'(n_out - n0), 32'd0);
    send(4'h0);
    idle(3);
    check("enables_cleared", 32'(out_data), 32'd0);

`ifdef PLA_TOGGLE_CNT_EN
    // Toggle counting: 00 -> 7F -> 01 gives 7 then 13.
    cfg_write(4'd0, 1'b1, 4'hF, 4'h0, 7'h7F);
    cfg_write(4'd1, 1'b1, 4'h8, 4'h8, 7'h01);
    send(4'h3); send(4'h0); send(4'h8);
    idle(4);
    check("toggle_13", toggle_cnt, 32'd13);
    send(4'h0);
    idle(1);
    check("clr_hs_valid", 32'(out_valid), 32'd1);
    toggle_clr = 1'b1;
    idle(1);
    toggle_clr = 1'b0;
    check("toggle_clr", toggle_cnt, 32'd0);
    idle(2);
`endif

    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pla_eval_engine.md
PLA_EVAL_ENGINE -- requirements
Module: pla_eval_engine

Interface
REQ-001 SHALL have parameter N_IN, default 4, input variable count (1..16).
REQ-002 SHALL have parameter N_OUT, default 7, output function count (1..32).
REQ-003 SHALL have parameter N_TERM, default 16, product-term capacity (2..64); TW = $clog2(N_TERM).
REQ-004 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have ports cfg_valid in 1 and cfg_ready out 1, the term-write handshake.
REQ-007 SHALL have ports cfg_idx in TW, cfg_en in 1, cfg_care in N_IN, cfg_val in N_IN and cfg_out in N_OUT, carrying the term slot, term enable, input care mask, required input values and OR-plane mask.
REQ-008 SHALL have ports in_valid in 1, in_ready out 1 and in_data in N_IN, the input-vector handshake.
REQ-009 SHALL have ports out_valid out 1, out_ready in 1 and out_data out N_OUT, the result handshake.
REQ-010 SHALL have ports toggle_clr in 1 and toggle_cnt out 32, present only under PLA_TOGGLE_CNT_EN.

Function
REQ-011 SHALL latch cfg_en/care/val/out into slot cfg_idx on cfg_valid&&cfg_ready; cfg_idx >= N_TERM SHALL be accepted and discarded.
REQ-012 SHALL drive cfg_ready=1 only when both pipeline stages are empty and in_valid=0.
REQ-013 SHALL treat term t as matching when enabled and ((in_data ^ val_t) & care_t)==0; care=0 matches all inputs.
REQ-014 SHALL compute out_data as the bitwise OR of cfg_out over matching terms, and 0 when no term matches.
REQ-015 SHALL be a 2-stage pipeline (S1 registers the term-match vector, S2 registers the OR result); latency from input handshake to out_valid is 2 cycles.
REQ-016 SHALL sustain 1 vector/cycle when out_ready=1; S2 holds out_data stable while out_valid&&!out_ready.
REQ-017 SHALL drive in_ready = !(S1 full && S2 full && !out_ready) and SHALL NOT drop or duplicate vectors under backpressure.
REQ-018 SHALL keep out_data unchanged when S2 is empty.
REQ-019 SHALL never start a term write while a vector is in flight, so every vector sees one consistent table.

Reset
REQ-020 SHALL, while rst=1, clear all term enables, empty S1/S2, and drive out_valid=0, out_data=0, cfg_ready=0, in_ready=0 and toggle_cnt=0.
REQ-021 SHALL discard in-flight vectors on rst asserted mid-operation; the first handshake is possible the cycle after rst deasserts.
REQ-022 SHALL hold term care/val/out contents unreset; only the enables clear.

Configuration
REQ-023 SHALL, when PLA_TOGGLE_CNT_EN is defined, add toggle_cnt counting popcount(out_data ^ prev_out) at each out handshake, prev_out reset to 0 and updated per handshake.
REQ-024 SHALL saturate toggle_cnt at 2^32-1; toggle_clr=1 SHALL zero it, taking priority over a same-cycle increment.
REQ-025 SHALL, without PLA_TOGGLE_CNT_EN, omit the toggle_clr/toggle_cnt ports and all associated registers.

Structure
REQ-026 SHALL take the default N_IN/N_OUT/N_TERM, the counter width 32 and the pipeline latency constant 2 from package pla_eval_pkg.
REQ-027 SHALL place the term table and match vector in sub-module pla_term_array; pla_eval_engine holds the handshakes, pipeline and counter.

Verification
REQ-028 SHALL cover this scenario: after reset with no terms loaded, in_data=4'hA -> out_data=7'h00 two cycles later, out_valid=1.
REQ-029 SHALL cover this scenario: load term0 care=4'hF val=4'h0 out=7'h7F and term1 care=4'h8 val=4'h8 out=7'h01; inputs 0,8,3 -> outputs 7'h7F,7'h01,7'h00.
REQ-030 SHALL cover this scenario: a 10-vector stream with out_ready held 0 for cycles 3..6 -> in_ready falls, and all 10 results arrive in order with none lost.
REQ-031 SHALL cover this scenario: cfg_valid asserted while 2 vectors are in flight -> cfg_ready=0 until both drain, and in-flight results use the old table.
REQ-032 SHALL cover this scenario: rst pulsed with S1 and S2 full -> out_valid=0 next cycle, all enables 0, and no stale result is emitted afterward.
REQ-033 SHALL cover this scenario (PLA_TOGGLE_CNT_EN): outputs 7'h00 -> 7'h7F -> 7'h01 -> toggle_cnt=7 then 13; toggle_clr with a same-cycle handshake -> 0.
